// File: rtl/band_playback_scheduler.sv
// band_playback_scheduler
// Time-multiplexes NUM_BANDS sample tables over one shared ROM read port.
// Each 44 kHz strobe walks every band through a FETCH/ACC pair (fixed
// latency), sums rom_data * gain for the enabled bands, then rounds down
// by 7 bits (Q1.7 gain), saturates to 16 bits and pulses valid_out.
module band_playback_scheduler #(
    parameter int NUM_BANDS  = 8,
    parameter int MEM_DEPTH  = 4036,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int BAND_W     = $clog2(NUM_BANDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_BANDS-1:0]      band_enable,
    input  logic [NUM_BANDS*8-1:0]    gain,
    input  logic                      overrun_clr,
    output logic                      rom_rd_en,
    output logic [BAND_W-1:0]         rom_band,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    input  logic signed [15:0]        rom_data,
    output logic signed [15:0]        data_out,
    output logic                      valid_out,
    output logic                      busy,
    output logic                      overrun
);

    // 16x9 product needs 25 bits; BAND_W extra bits absorb the sum of all bands.
    localparam int ACC_W = 25 + BAND_W;

    localparam logic [BAND_W-1:0]     IDX_LAST = BAND_W'(NUM_BANDS - 1);
    localparam logic [BAND_W-1:0]     IDX_ONE  = BAND_W'(32'd1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [BAND_W-1:0]       idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [NUM_BANDS-1:0]    mask_q, mask_d;
    logic signed [15:0]      data_out_q, data_out_d;
    logic                    valid_out_q, valid_out_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;

    logic [7:0]              gain_sel_s;
    logic signed [24:0]      mul_a_s;
    logic signed [24:0]      mul_b_s;
    logic signed [24:0]      prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] shift_s;
    logic [ACC_W-16:0]       shift_hi_s;
    logic                    fits_s;
    logic signed [15:0]      sat_s;
    logic                    drop_s;

    // Per-band product and the floor-shifted, saturated mix result.
    always_comb begin
        gain_sel_s = gain[{idx_q, 3'b000} +: 8];
        // Gain is unsigned, so it enters the signed multiply with a zero MSB.
        mul_a_s    = {{9{rom_data[15]}}, rom_data};
        mul_b_s    = {17'd0, gain_sel_s};
        prod_s     = mul_a_s * mul_b_s;
        prod_ext_s = {{(ACC_W-25){prod_s[24]}}, prod_s};
        shift_s    = acc_q >>> 3'd7;
        // Value fits in 16 bits when every bit above bit 14 matches the sign.
        shift_hi_s = shift_s[ACC_W-1:15];
        fits_s     = (&shift_hi_s) | ~(|shift_hi_s);
        if (fits_s) begin
            sat_s = shift_s[15:0];
        end else if (shift_s[ACC_W-1]) begin
            sat_s = 16'sh8000;
        end else begin
            sat_s = 16'sh7FFF;
        end
    end

    // Next-state logic for the band walk, accumulator, pointer and flags.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        drop_s      = enable && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    // Snapshot the band mask so later changes cannot disturb this sample.
                    mask_d  = band_enable;
                    acc_d   = {ACC_W{1'b0}};
                    idx_d   = {BAND_W{1'b0}};
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = ACC;
            end
            ACC: begin
                if (mask_q[idx_q]) begin
                    acc_d = acc_q + prod_ext_s;
                end else begin
                    acc_d = acc_q;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = FETCH;
                end
            end
            DONE: begin
                data_out_d  = sat_s;
                valid_out_d = 1'b1;
                if (ptr_q == PTR_LAST) begin
                    ptr_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A dropped strobe outranks a simultaneous clear.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= {BAND_W{1'b0}};
            ptr_q       <= {ADDR_WIDTH{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            mask_q      <= {NUM_BANDS{1'b0}};
            data_out_q  <= 16'sd0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // ROM request is decoded from the current state; band and address track idx/ptr.
    assign rom_rd_en = (state_q == FETCH) && mask_q[idx_q];
    assign rom_band  = idx_q;
    assign rom_addr  = ptr_q;

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_band_playback_scheduler.sv
// Scoreboard bench for band_playback_scheduler: stimulus pushes expected
// mix results computed from the ROM table contents; a monitor pops them
// whenever valid_out is seen and also checks ROM request addresses.
module tb_band_playback_scheduler;

    localparam int NB    = 8;
    localparam int DEPTH = 4036;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(NB);
    localparam int LAT   = 2 * NB + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [NB-1:0]         band_enable;
    logic [NB*8-1:0]       gain;
    logic                  overrun_clr;
    logic                  rom_rd_en;
    logic [BW-1:0]         rom_band;
    logic [AW-1:0]         rom_addr;
    logic signed [15:0]    rom_data = 16'sd0;
    logic signed [15:0]    data_out;
    logic                  valid_out;
    logic                  busy;
    logic                  overrun;

    band_playback_scheduler #(
        .NUM_BANDS (NB),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .band_enable (band_enable),
        .gain        (gain),
        .overrun_clr (overrun_clr),
        .rom_rd_en   (rom_rd_en),
        .rom_band    (rom_band),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [15:0] rom_mem [NB][DEPTH];

    typedef struct {
        int            data;
        int            due;
        int            ptr;
        logic [NB-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_ptr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Synchronous ROM: data appears the cycle after the read request.
    initial begin
        forever begin
            @(posedge clk);
            if (rom_rd_en) rom_data <= rom_mem[rom_band][rom_addr];
        end
    end

    // Reference: sum of enabled samples times gain, divided by 128 rounding
    // toward minus infinity, clamped to the signed 16-bit range.
    function automatic int model(input logic [NB-1:0] m, input logic [NB*8-1:0] g, input int p);
        longint total = 0;
        longint q;
        for (int i = 0; i < NB; i++) begin
            if (m[i]) total += longint'(rom_mem[i][p]) * longint'({56'd0, g[8*i +: 8]});
        end
        q = total / 128;
        if (total < 0 && (total % 128) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic logic [NB*8-1:0] rand_gain();
        logic [NB*8-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'($urandom);
        return r;
    endfunction

    task automatic fill_const(input logic signed [15:0] v);
        for (int i = 0; i < NB; i++)
            for (int j = 0; j < DEPTH; j++) rom_mem[i][j] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++)
            for (int j = 0; j < DEPTH; j++) rom_mem[i][j] = 16'($urandom);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one strobe while the DUT is idle and record what it must produce.
    task automatic accept(input logic [NB-1:0] m, input logic [NB*8-1:0] g);
        exp_t e;
        band_enable = m;
        gain        = g;
        enable      = 1'b1;
        e.data = model(m, g, model_ptr);
        e.due  = cyc + 1 + LAT;
        e.ptr  = model_ptr;
        e.mask = m;
        sb.push_back(e);
        model_ptr = (model_ptr == DEPTH - 1) ? 0 : model_ptr + 1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic run_sample(input logic [NB-1:0] m, input logic [NB*8-1:0] g, input bit scramble);
        accept(m, g);
        for (int k = 0; k < LAT; k++) begin
            if (scramble) band_enable = NB'($urandom);
            if (k == 7) chk("busy_mid_sample", busy, 1);
            tick(1);
        end
        chk("busy_after_sample", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rom_rd_en"}, rom_rd_en, 0);
        chk({tag, "_rom_band"},  rom_band, 0);
        chk({tag, "_rom_addr"},  rom_addr, 0);
        chk({tag, "_data_out"},  data_out, 0);
        chk({tag, "_valid_out"}, valid_out, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_overrun"},   overrun, 0);
    endtask

    // Monitor: checks ROM requests against the pending sample and pops the
    // scoreboard on every valid_out.
    initial begin
        int            rd_seen   = 0;
        int            last_data = 0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_seen   = 0;
                last_data = 0;
            end else begin
                if (rom_rd_en) begin
                    if (sb.size() == 0) begin
                        chk("rd_without_sample", 1, 0);
                    end else begin
                        chk("rom_addr", rom_addr, sb[0].ptr);
                        chk("rd_band_enabled", sb[0].mask[rom_band], 1);
                        rd_seen++;
                    end
                end
                if (valid_out) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("data_out", data_out, e.data);
                        chk("valid_latency", cyc, e.due);
                        chk("rd_count", rd_seen, $countones(e.mask));
                    end
                    rd_seen   = 0;
                    last_data = int'(data_out);
                end else begin
                    chk("data_hold", data_out, last_data);
                    if (sb.size() > 0 && cyc > sb[0].due) begin
                        chk("valid_timeout", cyc, sb[0].due);
                        void'(sb.pop_front());
                        rd_seen = 0;
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [NB-1:0] m;
        rst         = 1'b1;
        enable      = 1'b0;
        overrun_clr = 1'b0;
        band_enable = '0;
        gain        = '0;
        fill_const(16'sd0);
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);
        check_all_zero("post_reset");

        // All bands, unity gain, ROM = 100 -> 800 at address 0.
        fill_const(16'sd100);
        run_sample({NB{1'b1}}, {NB{8'd128}}, 1'b0);

        // Positive and negative saturation.
        fill_const(16'sd30000);
        run_sample(8'h03, {NB{8'd255}}, 1'b0);
        fill_const(-16'sd30000);
        run_sample(8'h03, {NB{8'd255}}, 1'b0);

        // Floor shift of a small negative product.
        fill_const(-16'sd1);
        run_sample(8'h01, {NB{8'd1}}, 1'b0);

        // Empty mask still produces a pulse with zero data.
        fill_random();
        run_sample(8'h00, rand_gain(), 1'b1);

        // Dropped strobe sets overrun; clear alone clears it.
        chk("overrun_idle", overrun, 0);
        accept(8'hA5, rand_gain());
        tick(5);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        chk("overrun_set", overrun, 1);
        tick(LAT - 6);
        chk("busy_after_drop", busy, 0);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Drop and clear in the same cycle: set wins.
        accept(8'h5A, rand_gain());
        tick(3);
        enable      = 1'b1;
        overrun_clr = 1'b1;
        tick(1);
        enable      = 1'b0;
        overrun_clr = 1'b0;
        chk("overrun_set_wins", overrun, 1);
        tick(LAT - 4);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("overrun_cleared_again", overrun, 0);

        // Randomised samples with band_enable churn during processing.
        repeat (30) run_sample(NB'($urandom), rand_gain(), 1'b1);

        // Reset in the middle of a sample aborts it.
        accept({NB{1'b1}}, rand_gain());
        tick(4);
        rst = 1'b1;
        sb.delete();
        model_ptr = 0;
        #1;
        check_all_zero("mid_reset");
        tick(2);
        rst = 1'b0;
        tick(3);

        // Walk the full table and wrap back to address 0.
        for (int k = 0; k < DEPTH + 1; k++) begin
            if (model_ptr == 0 || model_ptr == DEPTH - 1) m = {NB{1'b1}};
            else m = NB'($urandom);
            run_sample(m, rand_gain(), (k % 4) == 0);
        end

        tick(LAT + 3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
